regfile_writeback: RTL and testbench

//  Write-side front end of the core register file: merges the pipeline writeback stream
//  (fixed priority, never blocked) with out-of-order remote-load responses (valid/ready,

---
 rtl/regfile_wb_pkg.sv | 21 ++
 rtl/bsg_fifo_1r1w_small.sv | 75 +++++++
 rtl/regfile_writeback.sv | 126 ++++++++++++
 tb/tb_regfile_writeback.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback front end: buffered entry layout,
// arbiter state encoding and a width helper.
`define REGFILE_WB_DECLARE_S(aw, dw) \
  typedef struct packed { \
    logic [(aw)-1:0] addr; \
    logic [(dw)-1:0] data; \
  } rf_wb_s

package regfile_wb_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } wb_state_e;

  // Never returns 0, so a single-element range still gets a 1-bit field
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO with one write and one read port; also exposes per-slot
// valid bits and contents so the owner can decode what is buffered.
module bsg_fifo_1r1w_small
    import regfile_wb_pkg::*;
#(
    parameter  int unsigned width_p      = 32,
    parameter  int unsigned els_p        = 4,
    localparam int unsigned ptr_width_lp = safe_clog2(els_p),
    localparam int unsigned cnt_width_lp = $clog2(els_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             v_i,
    input  logic [width_p-1:0]               data_i,
    output logic                             ready_o,
    input  logic                             yumi_i,
    output logic                             v_o,
    output logic [width_p-1:0]               data_o,
    output logic [cnt_width_lp-1:0]          count_o,
    output logic [els_p-1:0]                 slot_v_o,
    output logic [els_p-1:0][width_p-1:0]    slot_data_o
);

    logic [els_p-1:0][width_p-1:0] r_mem;
    logic [ptr_width_lp-1:0]       r_rptr;
    logic [ptr_width_lp-1:0]       r_wptr;
    logic [cnt_width_lp-1:0]       r_cnt;
    logic [els_p-1:0]              r_slot_v;
    logic                          w_enq;
    logic                          w_deq;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Readiness depends only on stored count; a same-cycle dequeue does not free a slot
    assign ready_o     = (r_cnt < cnt_width_lp'(els_p));
    assign v_o         = (r_cnt != '0);
    assign w_enq       = v_i & ready_o;
    assign w_deq       = yumi_i & v_o;
    assign data_o      = r_mem[r_rptr];
    assign count_o     = r_cnt;
    assign slot_v_o    = r_slot_v;
    assign slot_data_o = r_mem;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rptr   <= '0;
            r_wptr   <= '0;
            r_cnt    <= '0;
            r_slot_v <= '0;
        end else begin
            if (w_deq) begin
                r_rptr           <= ptr_inc(r_rptr);
                r_slot_v[r_rptr] <= 1'b0;
            end
            if (w_enq) begin
                r_wptr           <= ptr_inc(r_wptr);
                r_slot_v[r_wptr] <= 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr] <= data_i;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port arbiter: pipeline writeback has fixed priority, remote-load
// responses are buffered and drained in idle cycles, with a forced stall on starvation.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter  int unsigned width_p           = 32,
  parameter  int unsigned els_p             = 32,
  parameter  int unsigned fifo_els_p        = 4,
  parameter  int unsigned starve_max_p      = 8,
  parameter  bit          x0_tied_to_zero_p = 1'b1,
  localparam int unsigned addr_width_lp     = safe_clog2(els_p),
  localparam int unsigned cnt_width_lp      = $clog2(fifo_els_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     int_v_i,
  input  logic [addr_width_lp-1:0] int_addr_i,
  input  logic [width_p-1:0]       int_data_i,
  output logic                     stall_o,
  input  logic                     rl_v_i,
  input  logic [addr_width_lp-1:0] rl_addr_i,
  input  logic [width_p-1:0]       rl_data_i,
  output logic                     rl_ready_o,
  output logic                     w_v_o,
  output logic [addr_width_lp-1:0] w_addr_o,
  output logic [width_p-1:0]       w_data_o,
  output logic [els_p-1:0]         pending_mask_o,
  output logic [cnt_width_lp-1:0]  pending_cnt_o
);

  `REGFILE_WB_DECLARE_S(addr_width_lp, width_p);

  localparam int unsigned starve_width_lp = safe_clog2(starve_max_p);

  wb_state_e                   r_state;
  wb_state_e                   w_state_n;
  logic [starve_width_lp-1:0]  r_starve;
  logic [starve_width_lp-1:0]  w_starve_n;

  rf_wb_s                      w_rl_entry;
  rf_wb_s                      w_head;
  rf_wb_s [fifo_els_p-1:0]     w_slot_data;
  logic [fifo_els_p-1:0]       w_slot_v;
  logic                        w_head_v;
  logic                        w_enq;
  logic                        w_deq;
  logic                        w_rl_drop;
  logic                        w_int_we;

  // A response to x0 still handshakes on rl_ready_o but is never stored
  assign w_rl_drop  = x0_tied_to_zero_p && (rl_addr_i == '0);
  assign w_enq      = rl_v_i & ~w_rl_drop;
  assign w_rl_entry = '{addr: rl_addr_i, data: rl_data_i};

  bsg_fifo_1r1w_small #(
    .width_p ($bits(rf_wb_s)),
    .els_p   (fifo_els_p)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (w_enq),
    .data_i      (w_rl_entry),
    .ready_o     (rl_ready_o),
    .yumi_i      (w_deq),
    .v_o         (w_head_v),
    .data_o      (w_head),
    .count_o     (pending_cnt_o),
    .slot_v_o    (w_slot_v),
    .slot_data_o (w_slot_data)
  );

  // Any pipeline valid, even a discarded x0 write, owns the port for the cycle
  assign w_int_we = int_v_i & ~(x0_tied_to_zero_p && (int_addr_i == '0));
  assign w_deq    = w_head_v & ~int_v_i;
  assign w_v_o    = w_int_we | w_deq;
  assign w_addr_o = int_v_i ? int_addr_i : w_head.addr;
  assign w_data_o = int_v_i ? int_data_i : w_head.data;
  assign stall_o  = (r_state == STALL);

  always_comb begin
    pending_mask_o = '0;
    for (int unsigned i = 0; i < fifo_els_p; i++) begin
      if (w_slot_v[i] && (32'(w_slot_data[i].addr) < els_p)) begin
        pending_mask_o[w_slot_data[i].addr] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_starve_n = r_starve;
    case (r_state)
      NORMAL: begin
        if (w_head_v && !w_deq) begin
          if (r_starve == starve_width_lp'(starve_max_p - 1)) begin
            w_state_n  = STALL;
            w_starve_n = '0;
          end else begin
            w_starve_n = r_starve + 1'b1;
          end
        end else begin
          w_starve_n = '0;
        end
      end
      STALL: begin
        w_state_n  = NORMAL;
        w_starve_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= NORMAL;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_n;
      r_starve <= w_starve_n;
    end
  end

  a_no_int_during_stall: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) (r_state == STALL) |-> !int_v_i
  );

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus randomized
// traffic, all checked against a queue-based model of the write-port rules.
module tb_regfile_writeback;

    localparam int unsigned W  = 32;
    localparam int unsigned E  = 32;
    localparam int unsigned FE = 4;
    localparam int unsigned SM = 8;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 3;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          int_v_i;
    logic [AW-1:0] int_addr_i;
    logic [W-1:0]  int_data_i;
    logic          stall_o;
    logic          rl_v_i;
    logic [AW-1:0] rl_addr_i;
    logic [W-1:0]  rl_data_i;
    logic          rl_ready_o;
    logic          w_v_o;
    logic [AW-1:0] w_addr_o;
    logic [W-1:0]  w_data_o;
    logic [E-1:0]  pending_mask_o;
    logic [CW-1:0] pending_cnt_o;

    always #5 clk_i = ~clk_i;

    regfile_writeback #(
        .width_p           (W),
        .els_p             (E),
        .fifo_els_p        (FE),
        .starve_max_p      (SM),
        .x0_tied_to_zero_p (1'b1)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .int_v_i        (int_v_i),
        .int_addr_i     (int_addr_i),
        .int_data_i     (int_data_i),
        .stall_o        (stall_o),
        .rl_v_i         (rl_v_i),
        .rl_addr_i      (rl_addr_i),
        .rl_data_i      (rl_data_i),
        .rl_ready_o     (rl_ready_o),
        .w_v_o          (w_v_o),
        .w_addr_o       (w_addr_o),
        .w_data_o       (w_data_o),
        .pending_mask_o (pending_mask_o),
        .pending_cnt_o  (pending_cnt_o)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: ordered list of buffered responses plus a blocked-cycle count
    logic [AW-1:0] q_addr[$];
    logic [W-1:0]  q_data[$];
    int unsigned   m_run;
    bit            m_stall;

    logic          e_ready, e_stall, e_wv;
    logic [AW-1:0] e_wa;
    logic [W-1:0]  e_wd;
    logic [E-1:0]  e_mask;
    logic [CW-1:0] e_cnt;

    task automatic model_reset();
        q_addr.delete();
        q_data.delete();
        m_run   = 0;
        m_stall = 1'b0;
    endtask

    // Drive one cycle's inputs (a compliant pipeline yields on stall) and predict outputs
    task automatic apply(input bit iv, input logic [AW-1:0] ia, input logic [W-1:0] id,
                         input bit rv, input logic [AW-1:0] ra, input logic [W-1:0] rd);
        int_v_i    = iv && !m_stall;
        int_addr_i = ia;
        int_data_i = id;
        rl_v_i     = rv;
        rl_addr_i  = ra;
        rl_data_i  = rd;
        e_ready = (q_addr.size() < FE);
        e_stall = m_stall;
        e_cnt   = CW'(q_addr.size());
        e_mask  = '0;
        for (int i = 0; i < q_addr.size(); i++) e_mask[q_addr[i]] = 1'b1;
        e_wv = 1'b0; e_wa = '0; e_wd = '0;
        if (int_v_i) begin
            e_wv = (ia != 0); e_wa = ia; e_wd = id;
        end else if (q_addr.size() > 0) begin
            e_wv = 1'b1; e_wa = q_addr[0]; e_wd = q_data[0];
        end
        @(negedge clk_i);
    endtask

    task automatic tick();
        bit deq, acc, blocked;
        deq     = !int_v_i && (q_addr.size() > 0);
        acc     = rl_v_i && (q_addr.size() < FE);
        blocked = (q_addr.size() > 0) && !deq;
        if (m_stall) begin
            m_stall = 1'b0;
            m_run   = 0;
        end else if (blocked) begin
            m_run++;
            if (m_run == SM) begin
                m_stall = 1'b1;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end
        if (deq) begin
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
        end
        if (acc && rl_addr_i != 0) begin
            q_addr.push_back(rl_addr_i);
            q_data.push_back(rl_data_i);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        int_v_i = 1'b0; int_addr_i = '0; int_data_i = '0;
        rl_v_i = 1'b0; rl_addr_i = '0; rl_data_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_tests += 5;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
        if (rl_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", rl_ready_o); end
        if (w_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_wv: got %b expected 0", w_v_o); end
        if (pending_mask_o !== '0) begin n_fail++; $display("FAIL reset_mask: got %h expected 0", pending_mask_o); end
        if (pending_cnt_o !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", pending_cnt_o); end
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        apply(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (w_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_first_cycle_wv: got %b expected 0", w_v_o); end
        tick();
    endtask

    task automatic test_pipeline();
        for (int i = 0; i < 5; i++) begin
            apply(1, AW'(5 + i), W'(32'hA0 + i), 0, 0, 0);
            n_tests += 3;
            if (w_v_o !== 1'b1) begin n_fail++; $display("FAIL pipe_wv[%0d]: got %b expected 1", i, w_v_o); end
            if (w_addr_o !== AW'(5 + i)) begin n_fail++; $display("FAIL pipe_addr[%0d]: got %0d expected %0d", i, w_addr_o, 5 + i); end
            if (w_data_o !== W'(32'hA0 + i)) begin n_fail++; $display("FAIL pipe_data[%0d]: got %h expected %h", i, w_data_o, 32'hA0 + i); end
            tick();
        end
    endtask

    task automatic test_remote_order();
        logic [AW-1:0] ra [4];
        logic [W-1:0]  rd [4];
        logic [E-1:0]  pre_mask [4];
        ra = '{5'd3, 5'd4, 5'd3, 5'd7};
        rd = '{32'h11, 32'h22, 32'h33, 32'h44};
        pre_mask = '{32'h98, 32'h98, 32'h88, 32'h80};
        for (int k = 0; k < 4; k++) begin
            apply(1, 10, 32'h55, 1, ra[k], rd[k]);
            n_tests++;
            if (rl_ready_o !== 1'b1) begin n_fail++; $display("FAIL order_ready[%0d]: got %b expected 1", k, rl_ready_o); end
            tick();
        end
        apply(1, 10, 32'h55, 0, 0, 0);
        n_tests += 3;
        if (rl_ready_o !== 1'b0) begin n_fail++; $display("FAIL order_full_ready: got %b expected 0", rl_ready_o); end
        if (pending_mask_o !== 32'h98) begin n_fail++; $display("FAIL order_mask: got %h expected 00000098", pending_mask_o); end
        if (pending_cnt_o !== 3'd4) begin n_fail++; $display("FAIL order_cnt: got %0d expected 4", pending_cnt_o); end
        tick();
        for (int k = 0; k < 4; k++) begin
            apply(0, 0, 0, 0, 0, 0);
            n_tests += 4;
            if (pending_mask_o !== pre_mask[k]) begin n_fail++; $display("FAIL drain_mask[%0d]: got %h expected %h", k, pending_mask_o, pre_mask[k]); end
            if (w_v_o !== 1'b1) begin n_fail++; $display("FAIL drain_wv[%0d]: got %b expected 1", k, w_v_o); end
            if (w_addr_o !== ra[k]) begin n_fail++; $display("FAIL drain_addr[%0d]: got %0d expected %0d", k, w_addr_o, ra[k]); end
            if (w_data_o !== rd[k]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", k, w_data_o, rd[k]); end
            tick();
        end
        apply(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (pending_mask_o !== '0) begin n_fail++; $display("FAIL drain_mask_end: got %h expected 0", pending_mask_o); end
        tick();
    endtask

    task automatic test_starve();
        apply(1, 12, 32'h77, 1, 9, 32'hC9);
        tick();
        for (int k = 1; k <= 10; k++) begin
            apply(1, 12, 32'h77, 0, 0, 0);
            n_tests++;
            if (stall_o !== (k == 9)) begin n_fail++; $display("FAIL starve_stall[%0d]: got %b expected %b", k, stall_o, k == 9); end
            if (k == 9) begin
                n_tests += 3;
                if (w_v_o !== 1'b1) begin n_fail++; $display("FAIL starve_wv: got %b expected 1", w_v_o); end
                if (w_addr_o !== 5'd9) begin n_fail++; $display("FAIL starve_addr: got %0d expected 9", w_addr_o); end
                if (w_data_o !== 32'hC9) begin n_fail++; $display("FAIL starve_data: got %h expected c9", w_data_o); end
            end
            if (k == 10) begin
                n_tests++;
                if (pending_cnt_o !== '0) begin n_fail++; $display("FAIL starve_cnt: got %0d expected 0", pending_cnt_o); end
            end
            tick();
        end
    endtask

    task automatic test_x0();
        apply(1, 0, 32'hFF, 1, 0, 32'h99);
        n_tests += 2;
        if (w_v_o !== 1'b0) begin n_fail++; $display("FAIL x0_int_wv: got %b expected 0", w_v_o); end
        if (rl_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b expected 1", rl_ready_o); end
        tick();
        apply(0, 0, 0, 0, 0, 0);
        n_tests += 3;
        if (w_v_o !== 1'b0) begin n_fail++; $display("FAIL x0_rl_wv: got %b expected 0", w_v_o); end
        if (pending_cnt_o !== '0) begin n_fail++; $display("FAIL x0_cnt: got %0d expected 0", pending_cnt_o); end
        if (pending_mask_o !== '0) begin n_fail++; $display("FAIL x0_mask: got %h expected 0", pending_mask_o); end
        tick();
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            apply(1, 13, 32'h1, 1, AW'(20 + k), W'(32'hF0 + k));
            tick();
        end
        apply(0, 0, 0, 1, 25, 32'hE5);
        n_tests += 2;
        if (rl_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", rl_ready_o); end
        if (w_addr_o !== 5'd20) begin n_fail++; $display("FAIL full_deq_addr: got %0d expected 20", w_addr_o); end
        tick();
        apply(0, 0, 0, 1, 26, 32'hE6);
        n_tests += 2;
        if (rl_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_next_ready: got %b expected 1", rl_ready_o); end
        if (pending_cnt_o !== 3'd3) begin n_fail++; $display("FAIL full_next_cnt: got %0d expected 3", pending_cnt_o); end
        tick();
        apply(0, 0, 0, 0, 0, 0);
        n_tests += 2;
        if (pending_cnt_o !== 3'd3) begin n_fail++; $display("FAIL full_after_cnt: got %0d expected 3", pending_cnt_o); end
        if (pending_mask_o !== 32'h04C0_0000) begin n_fail++; $display("FAIL full_after_mask: got %h expected 04c00000", pending_mask_o); end
        tick();
        for (int k = 0; k < 2; k++) begin
            apply(0, 0, 0, 0, 0, 0);
            n_tests++;
            if (w_addr_o !== e_wa) begin n_fail++; $display("FAIL full_drain_addr[%0d]: got %0d expected %0d", k, w_addr_o, e_wa); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            apply($urandom_range(0, 9) < 7, AW'($urandom), W'($urandom),
                  $urandom_range(0, 9) < 4, AW'($urandom), W'($urandom));
            n_tests += 5;
            if (stall_o !== e_stall) begin n_fail++; $display("FAIL rand_stall[%0d]: got %b expected %b", c, stall_o, e_stall); end
            if (rl_ready_o !== e_ready) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, rl_ready_o, e_ready); end
            if (w_v_o !== e_wv) begin n_fail++; $display("FAIL rand_wv[%0d]: got %b expected %b", c, w_v_o, e_wv); end
            if (pending_mask_o !== e_mask) begin n_fail++; $display("FAIL rand_mask[%0d]: got %h expected %h", c, pending_mask_o, e_mask); end
            if (pending_cnt_o !== e_cnt) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", c, pending_cnt_o, e_cnt); end
            if (e_wv) begin
                n_tests += 2;
                if (w_addr_o !== e_wa) begin n_fail++; $display("FAIL rand_addr[%0d]: got %0d expected %0d", c, w_addr_o, e_wa); end
                if (w_data_o !== e_wd) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", c, w_data_o, e_wd); end
            end
            tick();
        end
        for (int c = 0; c < FE + 1; c++) begin
            apply(0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            apply(1, 14, 32'h2, 1, AW'(1 + k), W'(32'hD0 + k));
            tick();
        end
        apply(0, 0, 0, 0, 0, 0);
        n_tests += 2;
        if (pending_cnt_o !== 3'd3) begin n_fail++; $display("FAIL rmid_pre_cnt: got %0d expected 3", pending_cnt_o); end
        if (w_v_o !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_wv: got %b expected 1", w_v_o); end
        #1 reset_n_i = 1'b0;
        #1;
        model_reset();
        n_tests += 5;
        if (w_v_o !== 1'b0) begin n_fail++; $display("FAIL rmid_wv: got %b expected 0", w_v_o); end
        if (rl_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", rl_ready_o); end
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rmid_stall: got %b expected 0", stall_o); end
        if (pending_mask_o !== '0) begin n_fail++; $display("FAIL rmid_mask: got %h expected 0", pending_mask_o); end
        if (pending_cnt_o !== '0) begin n_fail++; $display("FAIL rmid_cnt: got %0d expected 0", pending_cnt_o); end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        apply(0, 0, 0, 0, 0, 0);
        n_tests += 2;
        if (w_v_o !== 1'b0) begin n_fail++; $display("FAIL rmid_after_wv: got %b expected 0", w_v_o); end
        if (pending_cnt_o !== '0) begin n_fail++; $display("FAIL rmid_after_cnt: got %0d expected 0", pending_cnt_o); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pipeline();
        test_remote_order();
        test_starve();
        test_x0();
        test_full();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
